// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback,
// with memory-handshake timeout and a retired-instruction counter.
module cpu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [3:0]           opcode,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic                 jump,
  input  logic                 branchTaken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic [1:0]           pcSrc,
  output logic                 regWrite,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6,
    StError     = 3'd7
  } state_e;

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e               state_q;
  logic [WaitW-1:0]     wait_q;
  logic [CNT_WIDTH-1:0] count_q;
  // Access type captured on entry to MEMORY so the data-side outputs stay stable.
  logic                 rd_q;
  logic                 we_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      count_q <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            wait_q  <= '0;
          end
        end
        StFetch: begin
          if (imem_ready)            state_q <= StDecode;
          else if (wait_q == WaitLast) state_q <= StError;
          else                       wait_q  <= wait_q + 1'b1;
        end
        StDecode: begin
          state_q <= (opcode == HALT_OPCODE) ? StHalt : StExecute;
        end
        StExecute: begin
          if (memRead || memWrite) begin
            state_q <= StMemory;
            wait_q  <= '0;
            rd_q    <= memRead;
            we_q    <= memWrite;
          end else if (jump || branchTaken) begin
            state_q <= StFetch;
            wait_q  <= '0;
          end else begin
            state_q <= StWriteback;
          end
        end
        StMemory: begin
          if (dmem_ready) begin
            if (rd_q) begin
              state_q <= StWriteback;
            end else begin
              state_q <= StFetch;
              wait_q  <= '0;
            end
          end else if (wait_q == WaitLast) begin
            state_q <= StError;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StWriteback: begin
          state_q <= StFetch;
          wait_q  <= '0;
        end
        default: state_q <= state_q;
      endcase
      // Every PC update retires exactly one instruction.
      if (pcWrite) count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 2'b00;
    regWrite = 1'b0;
    case (state_q)
      StFetch: irWrite = imem_ready;
      StExecute: begin
        if (!(memRead || memWrite)) begin
          if (jump) begin
            pcWrite = 1'b1;
            pcSrc   = 2'b10;
          end else if (branchTaken) begin
            pcWrite = 1'b1;
            pcSrc   = 2'b01;
          end
        end
      end
      StMemory: pcWrite = dmem_ready && !rd_q;
      StWriteback: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_req    = (state_q == StFetch);
  assign dmem_req    = (state_q == StMemory);
  assign dmem_we     = (state_q == StMemory) && we_q;
  assign busy        = !(state_q inside {StIdle, StHalt, StError});
  assign halted      = (state_q == StHalt);
  assign timeout_err = (state_q == StError);
  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: expected per-cycle traces are built from the
// instruction-class latency rules and compared against the DUT outputs.
module tb_cpu_sequencer;

  localparam int MT = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        memRead = 1'b0, memWrite = 1'b0, jump = 1'b0, branchTaken = 1'b0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, irWrite, pcWrite, regWrite;
  logic        busy, halted, timeout_err;
  logic [1:0]  pcSrc;
  logic [15:0] instr_count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  cpu_sequencer #(.MEM_TIMEOUT(MT), .CNT_WIDTH(16), .HALT_OPCODE(4'b1111)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .memRead(memRead), .memWrite(memWrite), .jump(jump), .branchTaken(branchTaken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .instr_count(instr_count), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [13:0] exp;
    logic        ir;
    logic        dr;
  } cyc_t;

  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output vector; request/status flags follow from which phase we are in.
  function automatic logic [13:0] ev(input logic [2:0] st, input logic ir, input logic pcw,
                                     input logic [1:0] src, input logic rw, input logic dwe);
    return {st, ir, pcw, src, rw, st == 3'd1, st == 3'd4, dwe,
            !(st == 3'd0 || st == 3'd6 || st == 3'd7), st == 3'd6, st == 3'd7};
  endfunction

  function automatic logic [13:0] obs();
    return {state, irWrite, pcWrite, pcSrc, regWrite, imem_req, dmem_req, dmem_we,
            busy, halted, timeout_err};
  endfunction

  // Entered and left at posedge+1.
  task automatic step(input string tag, input logic st_in, input logic ir_rdy,
                      input logic dm_rdy, input logic [13:0] exp);
    start      = st_in;
    imem_ready = ir_rdy;
    dmem_ready = dm_rdy;
    #3;
    check(tag, 32'(obs()), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; jump = 1'b0; branchTaken = 1'b0; opcode = 4'd0;
    #1;
    check("reset_outputs", 32'(obs()), 32'(ev(3'd0, 0, 0, 2'b00, 0, 0)));
    check("reset_count", 32'(instr_count), 32'd0);
    exp_cnt = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic do_start();
    step("idle_start", 1'b1, 1'b0, 1'b0, ev(3'd0, 0, 0, 2'b00, 0, 0));
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 jump, 4 branch, 5 jump+branch, 6 load+store
  task automatic run_instr(input int kind, input int fw, input int mw);
    logic rd, wr, jp, br;
    rd = (kind == 1 || kind == 6);
    wr = (kind == 2 || kind == 6);
    jp = (kind == 3 || kind == 5);
    br = (kind == 4 || kind == 5);
    if (rd || wr) begin
      jp = rb();
      br = rb();
    end
    opcode = 4'($urandom_range(0, 14));
    memRead = rd; memWrite = wr; jump = jp; branchTaken = br;
    q.delete();
    for (int i = 0; i < fw; i++) q.push_back('{ev(3'd1, 0, 0, 2'b00, 0, 0), 1'b0, rb()});
    q.push_back('{ev(3'd1, 1, 0, 2'b00, 0, 0), 1'b1, rb()});
    q.push_back('{ev(3'd2, 0, 0, 2'b00, 0, 0), rb(), rb()});
    if (rd || wr) begin
      q.push_back('{ev(3'd3, 0, 0, 2'b00, 0, 0), rb(), rb()});
      for (int i = 0; i < mw; i++) q.push_back('{ev(3'd4, 0, 0, 2'b00, 0, wr), rb(), 1'b0});
      q.push_back('{ev(3'd4, 0, !rd, 2'b00, 0, wr), rb(), 1'b1});
      if (rd) q.push_back('{ev(3'd5, 0, 1, 2'b00, 1, 0), rb(), rb()});
    end else if (jp) begin
      q.push_back('{ev(3'd3, 0, 1, 2'b10, 0, 0), rb(), rb()});
    end else if (br) begin
      q.push_back('{ev(3'd3, 0, 1, 2'b01, 0, 0), rb(), rb()});
    end else begin
      q.push_back('{ev(3'd3, 0, 0, 2'b00, 0, 0), rb(), rb()});
      q.push_back('{ev(3'd5, 0, 1, 2'b00, 1, 0), rb(), rb()});
    end
    foreach (q[i]) step($sformatf("instr_k%0d_c%0d", kind, i), rb(), q[i].ir, q[i].dr, q[i].exp);
    exp_cnt = (exp_cnt + 1) & 32'hffff;
    check("instr_count", 32'(instr_count), 32'(exp_cnt));
  endtask

  initial begin
    #2;
    do_reset();
    do_start();
    // Directed: ALU, load with 3 wait cycles, store, jump+branch, branch.
    run_instr(0, 0, 0);
    run_instr(1, 0, 3);
    run_instr(2, 0, 0);
    run_instr(5, 0, 0);
    run_instr(4, 0, 0);
    for (int n = 0; n < 60; n++)
      run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));

    // Fetch timeout after exactly MT low cycles; ERROR is sticky and ignores start.
    do_reset();
    do_start();
    for (int i = 0; i < MT; i++) step("fetch_wait", 1'b0, 1'b0, 1'b0, ev(3'd1, 0, 0, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++) step("error_sticky", 1'b1, 1'b1, 1'b1, ev(3'd7, 0, 0, 2'b00, 0, 0));
    check("error_count", 32'(instr_count), 32'd0);

    // Ready on the limit cycle wins; then HALT opcode.
    do_reset();
    do_start();
    opcode = 4'b1111;
    for (int i = 0; i < MT - 1; i++) step("fetch_wait2", 1'b0, 1'b0, 1'b0, ev(3'd1, 0, 0, 2'b00, 0, 0));
    step("fetch_last_ready", 1'b0, 1'b1, 1'b0, ev(3'd1, 1, 0, 2'b00, 0, 0));
    step("decode_halt", 1'b0, 1'b0, 1'b0, ev(3'd2, 0, 0, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++) step("halt_sticky", 1'b1, 1'b1, 1'b1, ev(3'd6, 0, 0, 2'b00, 0, 0));
    check("halt_count", 32'(instr_count), 32'd0);

    // Asynchronous reset while a load is waiting in MEMORY.
    do_reset();
    do_start();
    opcode = 4'd3; memRead = 1'b1;
    step("ar_fetch", 1'b0, 1'b1, 1'b0, ev(3'd1, 1, 0, 2'b00, 0, 0));
    step("ar_decode", 1'b0, 1'b0, 1'b0, ev(3'd2, 0, 0, 2'b00, 0, 0));
    step("ar_exec", 1'b0, 1'b0, 1'b0, ev(3'd3, 0, 0, 2'b00, 0, 0));
    dmem_ready = 1'b0;
    #2;
    check("ar_mem_req", 32'(obs()), 32'(ev(3'd4, 0, 0, 2'b00, 0, 0)));
    reset_n = 1'b0;
    #1;
    check("ar_async_drop", 32'(obs()), 32'(ev(3'd0, 0, 0, 2'b00, 0, 0)));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    memRead = 1'b0;
    step("ar_idle", 1'b0, 1'b1, 1'b1, ev(3'd0, 0, 0, 2'b00, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the CPU core: steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes the decoded control outputs (memRead, memWrite, jump) plus the resolved branch condition.
- Drives the instruction-register, PC, register-file and data-memory enables.
- Handshakes with instruction and data memory, with a wait-cycle timeout, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles on a memory handshake before ERROR (≥2).
- CNT_WIDTH, 16: width of retired-instruction counter.
- HALT_OPCODE, 4'b1111: opcode that stops the sequencer.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- opcode  in  4  opcode field of the instruction register.
- memRead  in  1  decoded load.
- memWrite  in  1  decoded store.
- jump  in  1  decoded jump.
- branchTaken  in  1  resolved branch condition (any branch flag true and comparison met).
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable.
- irWrite  out  1  load instruction register.
- pcWrite  out  1  update PC.
- pcSrc  out  2  00 PC+1, 01 branch target, 10 jump target.
- regWrite  out  1  register file write.
- busy  out  1  state not IDLE/HALT/ERROR.
- halted  out  1  in HALT.
- timeout_err  out  1  in ERROR.
- instr_count  out  CNT_WIDTH  retired instructions.
- state  out  3  current state encoding.

Behaviour:
- Reset (reset_n low): immediate, asynchronous. state=IDLE, all outputs 0, instr_count=0, wait counter=0. Applies mid-operation in any state, including an open memory request, which drops the same instant.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- Output timing:
  - imem_req, dmem_req, dmem_we, busy, halted, timeout_err are Moore decodes of state.
  - irWrite, pcWrite, pcSrc, regWrite are combinational from state plus inputs, asserted only in the cycle that makes the transition.
  - pcSrc=00 whenever pcWrite=0.
- IDLE: start=1 → FETCH. start is ignored in every other state.
- FETCH:
  - imem_req=1.
  - imem_ready=1 → irWrite=1, go to DECODE.
- DECODE: one cycle. opcode==HALT_OPCODE → HALT; otherwise → EXECUTE.
- EXECUTE: one cycle; priority order:
  - memRead|memWrite → MEMORY.
  - jump → pcWrite=1, pcSrc=10, instr_count+1, → FETCH.
  - branchTaken → pcWrite=1, pcSrc=01, instr_count+1, → FETCH.
  - otherwise → WRITEBACK.
  - jump beats branchTaken when both are set.
- MEMORY:
  - dmem_req=1; dmem_we=memWrite, held for the whole state.
  - dmem_ready=1 with memRead=1 → WRITEBACK. memRead wins when both memRead and memWrite are set.
  - dmem_ready=1 with store only → pcWrite=1, pcSrc=00, instr_count+1, → FETCH. No regWrite.
- WRITEBACK: regWrite=1, pcWrite=1, pcSrc=00, instr_count+1, → FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEMORY.
  - Increments each cycle in FETCH/MEMORY while the respective ready is low.
  - If ready is low while the counter equals MEM_TIMEOUT-1 → ERROR, i.e. after exactly MEM_TIMEOUT low cycles.
  - Ready arriving in that limit cycle wins; no error.
- HALT and ERROR: sticky until reset. All enables 0, no requests.
- instr_count: wraps from all-ones to 0 silently.
- Instruction latency with zero-wait memory:
  - ALU op: 4 cycles (F,D,E,W).
  - Branch/jump: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.

Test Plan:
- Reset, start=1 one cycle, opcode=0001 with no mem/branch/jump, imem_ready=1 → state sequence 1,2,3,5,1; irWrite in cycle 1; regWrite+pcWrite (pcSrc=00) in WRITEBACK; instr_count=1.
- Load (memRead=1), dmem_ready low 3 cycles then high → dmem_req=1 for 4 cycles, dmem_we=0, then WRITEBACK with regWrite=1; instr_count increments by 1.
- Store (memWrite=1), dmem_ready immediate → dmem_we=1 in MEMORY; pcWrite=1 with pcSrc=00 on ready; regWrite never asserted; next state FETCH.
- EXECUTE with jump=1 and branchTaken=1 → pcSrc=10, pcWrite=1 for one cycle; then branchTaken only → pcSrc=01.
- MEM_TIMEOUT=16, imem_ready held low 16 cycles → state=7, timeout_err=1, start pulse ignored. Repeat with imem_ready high on the 16th cycle → DECODE, no error.
- opcode=1111 → HALT, halted=1, instr_count unchanged. Separately, reset_n low mid-MEMORY → dmem_req=0 and state=0 without waiting for a clock edge.
